mips_r2000_core: RTL and testbench
==================================

Name: mips_r2000_core

Overview:
- Classic 5-stage pipelined MIPS R2000 integer core: IF, ID, EX, MEM, WB.
- Contains on-chip byte-wide instruction and data memories, a 32x32 register file, a hazard detection unit and a forwarding unit.
- Top-level CPU block; the bench loads the program through a byte-write port and observes state through debug ports.

Parameters:
- IMEM_BYTES, 1024, instruction memory size in bytes (power of two).
- DMEM_BYTES, 1024, data memory size in bytes (power of two).

Ports:
- clk  in  1  rising-edge clock, sole clock.
- rst  in  1  reset, synchronous, active-low.
- imem_we  in  1  instruction memory byte write enable; usable in any cycle.
- imem_waddr  in  32  byte address for program load, taken modulo IMEM_BYTES.
- imem_wdata  in  8  byte to write.
- dbg_reg_sel  in  5  register index for debug read.
- dbg_reg_data  out  32  combinational read of register dbg_reg_sel.
- pc  out  32  current fetch PC.
- stall  out  1  high while the hazard unit holds PC and IF/ID.

Behaviour:
- Reset (rst=0 at a clk edge):
  - PC=0.
  - All pipeline registers cleared to bubble state: all control bits 0, so no register write and no memory access.
  - Register r[i]=i for i=0..31.
  - Memories are not cleared.
  - stall=0.
- Instruction memory:
  - Little-endian: word = {mem[a+3], mem[a+2], mem[a+1], mem[a]}, with a = PC modulo IMEM_BYTES and the low 2 bits forced to 0.
  - Read is combinational.
  - Program-load writes occur on the clk edge when imem_we=1.
- Fetch: PC increments by 4 each cycle unless stalled, wrapping modulo 2^32. There are no branches or jumps.
- Supported instructions; any other opcode or funct executes as a NOP (no writes):
  - R-type (opcode 0): add/addu (0x20/0x21), sub/subu (0x22/0x23), and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A (signed), sltu 0x2B, sll 0x00, srl 0x02, sra 0x03, sllv 0x04, srlv 0x06, srav 0x07.
  - Variable shifts use rs[4:0] as the shift amount and shift rt.
  - I-type: addi 0x08 (sign-extended immediate), andi 0x0C, ori 0x0D and xori 0x0E (zero-extended), lui 0x0F, lw 0x23, sw 0x2B.
  - No overflow traps; all arithmetic wraps modulo 2^32.
  - Destination is rd for R-type and rt for I-type. Writes to r0 are discarded; r0 always reads 0.
- Data memory:
  - Little-endian bytes.
  - Address = (rs + sign-extended offset) modulo DMEM_BYTES, with the low 2 bits ignored.
  - sw writes on the clk edge ending MEM.
  - lw reads combinationally in MEM.
- Latency and register file:
  - An instruction fetched in cycle n writes the register file on the clk edge ending cycle n+4.
  - The register file forwards a same-cycle WB write to ID reads (write-before-read).
- Forwarding (FORWARD_EN defined):
  - EX operands take the EX/MEM ALU result if that stage writes a nonzero matching register.
  - Otherwise they take the MEM/WB write data if it matches.
  - Otherwise they take the ID/EX register value.
  - EX/MEM has priority over MEM/WB.
  - Store data (rt) is forwarded the same way.
- Hazard detection (load-use):
  - Condition: ID/EX holds lw with rt≠0, and rt equals the rs or rt field of the instruction in ID.
  - Effect: stall=1 for exactly 1 cycle. PC and IF/ID hold; a bubble is inserted into ID/EX.
- imem writes during execution take effect for fetches in the following cycles.

Optional Feature:
- Macro FORWARD_EN.
- Defined: the forwarding unit is present; only load-use causes stalls, each 1 cycle.
- Undefined: no forwarding unit.
  - The hazard unit stalls the ID instruction while any nonzero source register matches a pending write destination in ID/EX or EX/MEM.
  - The ID write bypass still resolves a match in MEM/WB, so stalls last up to 2 cycles.
  - Architectural results are identical in both builds; only cycle counts differ.

Test Plan:
- Reset then idle with imem all zero (NOPs) → pc advances 0,4,8,…; r[i]=i; stall never asserted.
- Load bytes 02 00 42 20 | 04 00 63 20 | 06 20 43 00 (addi $2,$2,2; addi $3,$3,4; srlv $4,$3,$2) → after 8 cycles r2=4, r3=7, r4=0. Forwarding from EX/MEM and MEM/WB is exercised.
- add $11,$5,$6 then sub $12,$11,$7 back-to-back → r11=11, r12=4; FORWARD_EN build shows 0 stall cycles.
- sw $9,0($0); lw $13,0($0); addu $14,$13,$13 → r13=9, r14=18; stall=1 for exactly 1 cycle in FORWARD_EN build.
- addi $0,$0,5; lui $15,0x1234; ori $15,$15,0x5678; slt $16,$15,$0 → r0=0, r15=0x12345678, r16=0.
- Drive rst=0 mid-program for 1 edge → pc=0, all registers back to r[i]=i, no stray write from in-flight instructions.

Source files
------------

// File: rtl/mips_r2000_core.sv
// mips_r2000_core: 5-stage (IF/ID/EX/MEM/WB) MIPS R2000 integer subset with
// on-chip little-endian byte-wide instruction and data memories.
// Build option: define FORWARD_EN to add the EX-stage forwarding unit. Without
// it, the hazard unit stalls ID until producers reach MEM/WB.
module mips_r2000_core #(
    parameter int IMEM_BYTES = 1024,
    parameter int DMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_we,
    input  logic [31:0] imem_waddr,
    input  logic [7:0]  imem_wdata,
    input  logic [4:0]  dbg_reg_sel,
    output logic [31:0] dbg_reg_data,
    output logic [31:0] pc,
    output logic        stall
);
    localparam int IA = $clog2(IMEM_BYTES);
    localparam int DA = $clog2(DMEM_BYTES);

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
        ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;

    typedef struct packed {
        logic        we;
        logic        lw;
        logic        sw;
        alu_op_e     alu;
        logic        use_imm;
        logic        var_sh;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [4:0]  shamt;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
    } idex_t;

    typedef struct packed {
        logic        we;
        logic        lw;
        logic        sw;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] st;
    } exmem_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] data;
    } memwb_t;

    logic [31:0] pc_q, pc_d, ifid_q, ifid_d;
    idex_t       idex_q, idex_d;
    exmem_t      exmem_q, exmem_d;
    memwb_t      memwb_q, memwb_d;
    logic [31:0] rf_q [32];
    logic [7:0]  imem_q [IMEM_BYTES];
    logic [7:0]  dmem_q [DMEM_BYTES];

    // ---------------- IF ----------------
    logic [IA-1:0] ia;
    logic [31:0]   if_instr;
    assign ia       = {pc_q[IA-1:2], 2'b00};
    assign if_instr = {imem_q[ia | IA'(3)], imem_q[ia | IA'(2)],
                       imem_q[ia | IA'(1)], imem_q[ia]};
    assign pc       = pc_q;
    assign pc_d     = stall ? pc_q : pc_q + 32'd4;
    assign ifid_d   = stall ? ifid_q : if_instr;

    // Program-load port; no reset so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (imem_we) imem_q[imem_waddr[IA-1:0]] <= imem_wdata;
    end

    // ---------------- ID ----------------
    logic [5:0]  id_op, id_fn;
    logic [4:0]  id_rs, id_rt, id_rd, id_sh;
    logic [15:0] id_imm;
    logic [31:0] id_rs_val, id_rt_val;
    assign id_op  = ifid_q[31:26];
    assign id_rs  = ifid_q[25:21];
    assign id_rt  = ifid_q[20:16];
    assign id_rd  = ifid_q[15:11];
    assign id_sh  = ifid_q[10:6];
    assign id_fn  = ifid_q[5:0];
    assign id_imm = ifid_q[15:0];

    // Register reads see a same-cycle WB write.
    assign id_rs_val = (id_rs == 5'd0) ? 32'd0 :
                       (memwb_q.we && memwb_q.dest == id_rs) ? memwb_q.data : rf_q[id_rs];
    assign id_rt_val = (id_rt == 5'd0) ? 32'd0 :
                       (memwb_q.we && memwb_q.dest == id_rt) ? memwb_q.data : rf_q[id_rt];
    assign dbg_reg_data = (dbg_reg_sel == 5'd0) ? 32'd0 : rf_q[dbg_reg_sel];

`ifdef FORWARD_EN
    assign stall = idex_q.lw && (idex_q.dest != 5'd0) &&
                   ((idex_q.dest == id_rs) || (idex_q.dest == id_rt));
`else
    logic id_use_rt;
    assign id_use_rt = (id_op == 6'h00) || (id_op == 6'h2B);
    assign stall = (idex_q.we  && ((idex_q.dest  == id_rs) || (id_use_rt && idex_q.dest  == id_rt))) ||
                   (exmem_q.we && ((exmem_q.dest == id_rs) || (id_use_rt && exmem_q.dest == id_rt)));
`endif

    // Decode into ID/EX; unsupported encodings and stalls become bubbles.
    always_comb begin
        idex_d         = '0;
        idex_d.rs      = id_rs;
        idex_d.rt      = id_rt;
        idex_d.dest    = id_rd;
        idex_d.shamt   = id_sh;
        idex_d.rs_val  = id_rs_val;
        idex_d.rt_val  = id_rt_val;
        idex_d.imm     = {{16{id_imm[15]}}, id_imm};
        idex_d.alu     = ALU_ADD;
        case (id_op)
            6'h00: begin
                idex_d.we = 1'b1;
                case (id_fn)
                    6'h20, 6'h21: idex_d.alu = ALU_ADD;
                    6'h22, 6'h23: idex_d.alu = ALU_SUB;
                    6'h24: idex_d.alu = ALU_AND;
                    6'h25: idex_d.alu = ALU_OR;
                    6'h26: idex_d.alu = ALU_XOR;
                    6'h27: idex_d.alu = ALU_NOR;
                    6'h2A: idex_d.alu = ALU_SLT;
                    6'h2B: idex_d.alu = ALU_SLTU;
                    6'h00: idex_d.alu = ALU_SLL;
                    6'h02: idex_d.alu = ALU_SRL;
                    6'h03: idex_d.alu = ALU_SRA;
                    6'h04: begin idex_d.alu = ALU_SLL; idex_d.var_sh = 1'b1; end
                    6'h06: begin idex_d.alu = ALU_SRL; idex_d.var_sh = 1'b1; end
                    6'h07: begin idex_d.alu = ALU_SRA; idex_d.var_sh = 1'b1; end
                    default: idex_d.we = 1'b0;
                endcase
            end
            6'h08: begin idex_d.we = 1'b1; idex_d.dest = id_rt; idex_d.use_imm = 1'b1; end
            6'h0C: begin idex_d.we = 1'b1; idex_d.dest = id_rt; idex_d.use_imm = 1'b1;
                         idex_d.alu = ALU_AND; idex_d.imm = {16'd0, id_imm}; end
            6'h0D: begin idex_d.we = 1'b1; idex_d.dest = id_rt; idex_d.use_imm = 1'b1;
                         idex_d.alu = ALU_OR;  idex_d.imm = {16'd0, id_imm}; end
            6'h0E: begin idex_d.we = 1'b1; idex_d.dest = id_rt; idex_d.use_imm = 1'b1;
                         idex_d.alu = ALU_XOR; idex_d.imm = {16'd0, id_imm}; end
            6'h0F: begin idex_d.we = 1'b1; idex_d.dest = id_rt; idex_d.alu = ALU_LUI; end
            6'h23: begin idex_d.we = 1'b1; idex_d.lw = 1'b1; idex_d.dest = id_rt;
                         idex_d.use_imm = 1'b1; end
            6'h2B: begin idex_d.sw = 1'b1; idex_d.use_imm = 1'b1; end
            default: ;
        endcase
        if (idex_d.dest == 5'd0) idex_d.we = 1'b0;
        if (stall) idex_d = '0;
    end

    // ---------------- EX ----------------
    logic [31:0] ex_a, ex_b, alu_b, alu_y;
    logic [4:0]  ex_sh;

    // Operand selection; a load in EX/MEM has no data yet and is never a source.
    always_comb begin
        ex_a = idex_q.rs_val;
        ex_b = idex_q.rt_val;
`ifdef FORWARD_EN
        if (exmem_q.we && !exmem_q.lw && exmem_q.dest == idex_q.rs) ex_a = exmem_q.alu;
        else if (memwb_q.we && memwb_q.dest == idex_q.rs)          ex_a = memwb_q.data;
        if (exmem_q.we && !exmem_q.lw && exmem_q.dest == idex_q.rt) ex_b = exmem_q.alu;
        else if (memwb_q.we && memwb_q.dest == idex_q.rt)          ex_b = memwb_q.data;
`endif
    end

    assign alu_b = idex_q.use_imm ? idex_q.imm : ex_b;
    assign ex_sh = idex_q.var_sh ? ex_a[4:0] : idex_q.shamt;

    // ALU; shifts always operate on rt.
    always_comb begin
        alu_y = 32'd0;
        case (idex_q.alu)
            ALU_ADD:  alu_y = ex_a + alu_b;
            ALU_SUB:  alu_y = ex_a - alu_b;
            ALU_AND:  alu_y = ex_a & alu_b;
            ALU_OR:   alu_y = ex_a | alu_b;
            ALU_XOR:  alu_y = ex_a ^ alu_b;
            ALU_NOR:  alu_y = ~(ex_a | alu_b);
            ALU_SLT:  alu_y = {31'd0, $signed(ex_a) < $signed(alu_b)};
            ALU_SLTU: alu_y = {31'd0, ex_a < alu_b};
            ALU_SLL:  alu_y = ex_b << ex_sh;
            ALU_SRL:  alu_y = ex_b >> ex_sh;
            ALU_SRA:  alu_y = $unsigned($signed(ex_b) >>> ex_sh);
            ALU_LUI:  alu_y = {idex_q.imm[15:0], 16'd0};
            default:  alu_y = 32'd0;
        endcase
    end

    assign exmem_d = '{we: idex_q.we, lw: idex_q.lw, sw: idex_q.sw,
                       dest: idex_q.dest, alu: alu_y, st: ex_b};

    // ---------------- MEM ----------------
    logic [DA-1:0] da;
    logic [31:0]   mem_rdata;
    assign da        = {exmem_q.alu[DA-1:2], 2'b00};
    assign mem_rdata = {dmem_q[da | DA'(3)], dmem_q[da | DA'(2)],
                        dmem_q[da | DA'(1)], dmem_q[da]};
    assign memwb_d   = '{we: exmem_q.we, dest: exmem_q.dest,
                         data: exmem_q.lw ? mem_rdata : exmem_q.alu};

    // Store on the edge ending MEM; an in-flight store is dropped by reset.
    always_ff @(posedge clk) begin
        if (rst && exmem_q.sw) begin
            dmem_q[da]          <= exmem_q.st[7:0];
            dmem_q[da | DA'(1)] <= exmem_q.st[15:8];
            dmem_q[da | DA'(2)] <= exmem_q.st[23:16];
            dmem_q[da | DA'(3)] <= exmem_q.st[31:24];
        end
    end

    // Pipeline registers; reset leaves every stage a bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= 32'd0;
            ifid_q  <= 32'd0;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    // Register file; reset seeds r[i]=i, r0 is never written.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'(i);
        end else if (memwb_q.we) begin
            rf_q[memwb_q.dest] <= memwb_q.data;
        end
    end

`ifdef FORWARD_EN
    logic unused_bits;
    assign unused_bits = ^{imem_waddr[31:IA]};
`else
    logic unused_bits;
    assign unused_bits = ^{imem_waddr[31:IA], idex_q.rs, idex_q.rt};
`endif
endmodule

// File: tb/tb_mips_r2000_core.sv
// Scoreboard bench for mips_r2000_core: stimulus pushes expected values into
// a queue, a negedge monitor pops one entry per cycle and compares it with the
// DUT observation (register via debug port, pc, stall, or stall-cycle count).
module tb_mips_r2000_core;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_we = 1'b0;
    logic [31:0] imem_waddr = 32'd0;
    logic [7:0]  imem_wdata = 8'd0;
    logic [4:0]  dbg_reg_sel = 5'd0;
    logic [31:0] dbg_reg_data;
    logic [31:0] pc;
    logic        stall;

    always #5 clk = ~clk;

    mips_r2000_core #(.IMEM_BYTES(1024), .DMEM_BYTES(1024)) dut (
        .clk(clk), .rst(rst), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .dbg_reg_sel(dbg_reg_sel),
        .dbg_reg_data(dbg_reg_data), .pc(pc), .stall(stall)
    );

`ifdef FORWARD_EN
    localparam int ST_T2 = 0, ST_T3 = 0, ST_T4 = 1, ST_T5 = 0;
`else
    localparam int ST_T2 = 2, ST_T3 = 2, ST_T4 = 2, ST_T5 = 4;
`endif

    localparam logic [1:0] K_REG = 2'd0, K_PC = 2'd1, K_STALL = 2'd2, K_STCNT = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  sel;
        logic [31:0] exp;
    } chk_t;

    chk_t        chkq[$];
    string       nameq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          stall_cnt = 0;
    logic [31:0] prog [16];

    // Stall cycles since the last reset release.
    always @(negedge clk) begin
        if (!rst) stall_cnt = 0;
        else if (stall) stall_cnt = stall_cnt + 1;
    end

    // Monitor: one expectation per cycle, compared away from the active edge.
    always @(negedge clk) begin : monitor
        chk_t        c;
        string       nm;
        logic [31:0] act;
        if (chkq.size() > 0) begin
            c   = chkq.pop_front();
            nm  = nameq.pop_front();
            act = 32'd0;
            case (c.kind)
                K_REG:   begin dbg_reg_sel = c.sel; #1; act = dbg_reg_data; end
                K_PC:    act = pc;
                K_STALL: act = {31'd0, stall};
                default: act = 32'(stall_cnt);
            endcase
            n_cmp++;
            if (act !== c.exp) begin
                n_err++;
                $display("FAIL %s: actual 0x%08h required 0x%08h", nm, act, c.exp);
            end
        end
    end

    task automatic expect_val(input logic [1:0] k, input logic [4:0] s,
                              input logic [31:0] e, input string nm);
        chk_t c;
        c.kind = k; c.sel = s; c.exp = e;
        chkq.push_back(c);
        nameq.push_back(nm);
    endtask

    task automatic expect_reg(input int r, input logic [31:0] e, input string nm);
        expect_val(K_REG, 5'(r), e, nm);
    endtask

    task automatic drain();
        int b = 0;
        while (chkq.size() > 0 && b < 200) begin
            @(posedge clk);
            b++;
        end
        if (chkq.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: pending=%0d required=0", chkq.size());
            chkq.delete();
            nameq.delete();
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 32'd0;
    endtask

    // Holds reset while writing the 16-word program (zero padded) at address 0.
    task automatic load_prog();
        rst = 1'b0;
        for (int w = 0; w < 16; w++) begin
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                imem_we    = 1'b1;
                imem_waddr = 32'(w * 4 + b);
                imem_wdata = prog[w][8*b +: 8];
            end
        end
        @(negedge clk);
        imem_we = 1'b0;
    endtask

    task automatic run_prog(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) begin
            @(negedge clk);
            imem_we = 1'b1; imem_waddr = 32'(a); imem_wdata = 8'd0;
        end
        @(negedge clk);
        imem_we = 1'b0;

        // T1: reset state, then idle NOPs
        clear_prog();
        load_prog();
        @(posedge clk); #1;
        expect_val(K_PC, 5'd0, 32'd0, "reset_pc");
        expect_val(K_STALL, 5'd0, 32'd0, "reset_stall");
        expect_reg(0, 32'd0, "reset_r0");
        expect_reg(1, 32'd1, "reset_r1");
        expect_reg(17, 32'd17, "reset_r17");
        expect_reg(31, 32'd31, "reset_r31");
        drain();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            expect_val(K_PC, 5'd0, 32'(4 * k), "idle_pc");
        end
        drain();
        expect_val(K_STCNT, 5'd0, 32'd0, "idle_stalls");
        drain();

        // T2: addi/addi/srlv chain
        clear_prog();
        prog[0] = 32'h20420002; prog[1] = 32'h20630004; prog[2] = 32'h00432006;
        load_prog();
        run_prog(16);
        expect_reg(2, 32'd4, "t2_r2");
        expect_reg(3, 32'd7, "t2_r3");
        expect_reg(4, 32'd0, "t2_r4");
        expect_val(K_STCNT, 5'd0, 32'(ST_T2), "t2_stalls");
        drain();

        // T3: add then dependent sub
        clear_prog();
        prog[0] = 32'h00A65820; prog[1] = 32'h01676022;
        load_prog();
        run_prog(16);
        expect_reg(11, 32'd11, "t3_r11");
        expect_reg(12, 32'd4, "t3_r12");
        expect_val(K_STCNT, 5'd0, 32'(ST_T3), "t3_stalls");
        drain();

        // T4: sw, lw, load-use addu
        clear_prog();
        prog[0] = 32'hAC090000; prog[1] = 32'h8C0D0000; prog[2] = 32'h01AD7021;
        load_prog();
        run_prog(16);
        expect_reg(13, 32'd9, "t4_r13");
        expect_reg(14, 32'd18, "t4_r14");
        expect_val(K_STCNT, 5'd0, 32'(ST_T4), "t4_stalls");
        drain();

        // T5: r0 write discarded, lui/ori, signed slt
        clear_prog();
        prog[0] = 32'h20000005; prog[1] = 32'h3C0F1234;
        prog[2] = 32'h35EF5678; prog[3] = 32'h01E0802A;
        load_prog();
        run_prog(20);
        expect_reg(0, 32'd0, "t5_r0");
        expect_reg(15, 32'h12345678, "t5_r15");
        expect_reg(16, 32'd0, "t5_r16");
        expect_val(K_STCNT, 5'd0, 32'(ST_T5), "t5_stalls");
        drain();

        // T6: reset while addi $20 is in WB and addi $21 in MEM
        clear_prog();
        prog[8] = 32'h20140055; prog[9] = 32'h20150066;
        load_prog();
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        expect_val(K_PC, 5'd0, 32'd0, "t6_rst_pc");
        expect_reg(20, 32'd20, "t6_rst_r20");
        expect_reg(21, 32'd21, "t6_rst_r21");
        @(negedge clk);
        rst = 1'b1;
        drain();
        repeat (20) @(posedge clk);
        #1;
        expect_reg(20, 32'h55, "t6_r20");
        expect_reg(21, 32'h66, "t6_r21");
        drain();

        // T7: remaining ALU ops
        clear_prog();
        prog[0]  = 32'h00228827; // nor  $17,$1,$2
        prog[1]  = 32'h00119043; // sra  $18,$17,1
        prog[2]  = 32'h00119902; // srl  $19,$17,4
        prog[3]  = 32'h0031B02B; // sltu $22,$1,$17
        prog[4]  = 32'h0221B82A; // slt  $23,$17,$1
        prog[5]  = 32'h3B18FFFF; // xori $24,$24,0xFFFF
        prog[6]  = 32'h33F9000C; // andi $25,$31,0xC
        prog[7]  = 32'h0003D0C0; // sll  $26,$3,3
        prog[8]  = 32'h0022D822; // sub  $27,$1,$2
        prog[9]  = 32'h0043E004; // sllv $28,$3,$2
        prog[10] = 32'h0051E807; // srav $29,$17,$2
        prog[11] = 32'h03E6F024; // and  $30,$31,$6
        prog[12] = 32'h20A5FFFD; // addi $5,$5,-3
        load_prog();
        run_prog(48);
        expect_reg(17, 32'hFFFFFFFC, "t7_nor");
        expect_reg(18, 32'hFFFFFFFE, "t7_sra");
        expect_reg(19, 32'h0FFFFFFF, "t7_srl");
        expect_reg(22, 32'd1, "t7_sltu");
        expect_reg(23, 32'd1, "t7_slt_neg");
        expect_reg(24, 32'h0000FFE7, "t7_xori");
        expect_reg(25, 32'd12, "t7_andi");
        expect_reg(26, 32'd24, "t7_sll");
        expect_reg(27, 32'hFFFFFFFF, "t7_sub");
        expect_reg(28, 32'd12, "t7_sllv");
        expect_reg(29, 32'hFFFFFFFF, "t7_srav");
        expect_reg(30, 32'd6, "t7_and");
        expect_reg(5, 32'd2, "t7_addi_neg");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
